sha256_engine_sched: RTL and testbench
======================================

# sha256_engine_sched

Dispatches 6-bit message IDs from the SHA-256 ID issuer to a pool of NUM_ENG hash engines. Allocation is round-robin, and engines may finish out of order. Retired IDs are re-emitted strictly in dispatch order. It sits between the ID issuer's ID stream and the downstream hash-output buffer, so completion order always matches message order.

## Interface
- NUM_ENG, 4: number of hash engines; 2..8.
- ID_W, 6: ID width; matches the issuer's id_out.
- clk  input  1  system clock; all logic on rising edge.
- sync_rst  input  1  synchronous reset, active-high; clears all state.
- en  input  1  dispatch enable; retirement continues when low.
- id_in  input  ID_W  incoming ID.
- id_in_last  input  1  last ID of packet.
- id_in_valid  input  1  incoming handshake valid.
- id_in_ready  output  1  incoming handshake ready.
- eng_start  output  NUM_ENG  one-hot, one-cycle start pulse per engine.
- eng_id  output  ID_W  ID accompanying eng_start.
- eng_done  input  NUM_ENG  per-engine completion pulse; multiple bits may be high in one cycle.
- id_out  output  ID_W  retired ID, dispatch order.
- id_out_last  output  1  last flag carried with the retired ID.
- id_out_valid  output  1  outgoing handshake valid.
- id_out_ready  input  1  outgoing handshake ready.
- alloc_mask  output  NUM_ENG  engines allocated (dispatched, not yet retired).
- err_spurious  output  1  sticky flag for a done pulse on a non-allocated or already-done engine.

## Operation
- Per-engine state: alloc bit and done bit. Order FIFO of depth NUM_ENG holds {engine index, id, last} per dispatch.
- An engine is allocated from dispatch until its ID retires at id_out, so the FIFO cannot overflow.
- Selection: round-robin pointer rr. Select the first engine with alloc=0, searching from rr upward modulo NUM_ENG. After each dispatch, rr = selected+1 (wrapping NUM_ENG-1 -> 0).
- id_in_ready = en & ~&alloc_mask, using the registered alloc state.
- Dispatch on id_in handshake:
  - set alloc[sel];
  - push {sel, id_in, id_in_last};
  - next cycle, eng_start[sel]=1 and eng_id=id_in.
- Done: eng_done[i] with alloc[i]=1 and done[i]=0 sets done[i]. Any other done pulse is ignored and sets err_spurious.
- Retire: when the FIFO is non-empty and done[head.idx]=1, present the head entry on id_out and id_out_last and assert id_out_valid.
  - On handshake: pop; clear alloc and done of head.idx.
  - Valid stays high and data stays stable until ready.
- Simultaneous events:
  - Dispatch and retire in the same cycle are both performed.
  - An engine freed by retirement is not selectable until the next cycle.
  - A done pulse for the head engine in the cycle its predecessor retires is captured normally.
  - A done pulse arriving in the same cycle as dispatch of that engine is spurious.
- en low mid-stream: no new dispatch. Done capture and retirement continue until the FIFO drains.
- sync_rst mid-operation: all alloc/done bits, FIFO, rr and err_spurious are cleared next edge. In-flight engine completions after reset count as spurious.

## Timing
- Reset values: id_in_ready=0 for the reset cycle, then en-dependent; eng_start=0; eng_id=0; id_out=0; id_out_last=0; id_out_valid=0; alloc_mask=0; err_spurious=0.
- Dispatch latency: eng_start pulses 1 cycle after the id_in handshake edge.
- Retire latency: id_out_valid rises 1 cycle after the edge sampling the head engine's eng_done. With id_out_ready held high, throughput is one retire per cycle.
- alloc_mask reflects register state and updates 1 cycle after a dispatch or retire handshake.
- id_out is registered; no combinational path exists from id_out_ready to id_out_valid, or from id_in_valid to id_in_ready.

## Configuration
- SHA256_SCHED_ERR_EN defined: spurious-done detection logic is present and err_spurious behaves as above.
- SHA256_SCHED_ERR_EN undefined: detection logic is removed; err_spurious is tied 0. Spurious pulses are still ignored via the alloc/done gating.

## Structure
- The shared package sha256_sched_pkg holds:
  - the ID_W default;
  - the entry typedef struct {idx, id, last};
  - the round-robin search function.
- One sub-module, sha256_sched_order_fifo: a parameterised synchronous FIFO of depth NUM_ENG with push, pop, head, empty and full.

## Test plan
- Basic order, NUM_ENG=4: dispatch IDs 0,1,2,3 (last on 3). eng_start sequence is 0001,0010,0100,1000. Done returned in engine order -> id_out 0,1,2,3 with last on 3.
- Out-of-order done: dispatch 5,6,7. Done for engines 2,1,0 on separate cycles -> no id_out until engine 0 done, then 5,6,7 on consecutive cycles.
- Full pool: 4 IDs in flight -> id_in_ready=0. Retire ID of engine 0 -> next dispatch goes to engine 0 one cycle later.
- Backpressure: id_out_ready low for 5 cycles with head done -> id_out_valid held, id_out stable. Dispatch continues until pool full.
- Spurious and simultaneous: eng_done=4'b1111 with only engines 0 and 1 allocated -> done[0], done[1] set; err_spurious=1 (only with SHA256_SCHED_ERR_EN; 0 otherwise).
- Reset mid-stream: sync_rst with 3 IDs in flight -> next cycle alloc_mask=0, id_out_valid=0, err_spurious=0. Next dispatch goes to engine 0.

Source files
------------

// File: rtl/sha256_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha256_sched_pkg
// Description : Shared definitions for the SHA-256 engine scheduler:
//               the default ID width, the order-FIFO entry layout and the
//               round-robin free-engine search.
// Revision    : 1.0 - initial release
// ============================================================================
package sha256_sched_pkg;

    // Default ID width; matches the issuer's id_out.
    localparam int c_ID_W_DEF = 6;
    // The scheduler supports up to 8 engines, so 3 index bits cover every build.
    localparam int c_MAX_ENG  = 8;
    localparam int c_IDX_W    = 3;

    // One dispatch record, kept in dispatch order until the ID retires.
    typedef struct packed {
        logic [c_IDX_W-1:0]    idx;
        logic [c_ID_W_DEF-1:0] id;
        logic                  last;
    } sched_entry_t;

    // First set bit of free_mask, searching upward from start and wrapping
    // at num_eng. Returns 0 when nothing is free; callers only use the result
    // while at least one engine is free.
    function automatic logic [c_IDX_W-1:0] rr_search(
        input logic [c_MAX_ENG-1:0] free_mask,
        input logic [c_IDX_W-1:0]   start,
        input int                   num_eng
    );
        logic [c_IDX_W-1:0]   sel;
        logic                 found;
        logic [c_MAX_ENG-1:0] shifted;
        int                   j;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < c_MAX_ENG; k++) begin
            j       = (int'(start) + k) % num_eng;
            shifted = free_mask >> j;
            if ((k < num_eng) && !found && shifted[0]) begin
                sel   = c_IDX_W'(j);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_sched_order_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sha256_sched_order_fifo
// Description : Synchronous FIFO holding dispatch records in dispatch order.
//               Push while full and pop while empty are ignored.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_push/i_data - write one entry
//               i_pop         - discard the head entry
//               o_head        - current head entry (valid when !o_empty)
//               o_empty/o_full- occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_sched_order_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full
);

    localparam int                 c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_CNT_W    = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_FULL_CNT);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sha256_engine_sched.sv
`default_nettype none
// ============================================================================
// Module      : sha256_engine_sched
// Description : Dispatches message IDs round-robin to NUM_ENG hash engines
//               and re-emits retired IDs strictly in dispatch order, even
//               when engines finish out of order.
// Ports       : clk, sync_rst         - clock, synchronous active-high reset
//               en                    - dispatch enable (retire always runs)
//               id_in/_last/_valid/_ready  - incoming ID stream
//               eng_start, eng_id     - one-cycle start pulse + ID per engine
//               eng_done              - per-engine completion pulses
//               id_out/_last/_valid/_ready - retired IDs in dispatch order
//               alloc_mask            - engines dispatched and not yet retired
//               err_spurious          - sticky unexpected-done flag
// Config      : SHA256_SCHED_ERR_EN - when defined, spurious-done detection
//               drives err_spurious; otherwise err_spurious is tied low.
//               ID_W must equal sha256_sched_pkg::c_ID_W_DEF (entry layout).
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_engine_sched
    import sha256_sched_pkg::*;
#(
    parameter int NUM_ENG = 4,
    parameter int ID_W    = c_ID_W_DEF
) (
    input  logic               clk,
    input  logic               sync_rst,
    input  logic               en,
    input  logic [ID_W-1:0]    id_in,
    input  logic               id_in_last,
    input  logic               id_in_valid,
    output logic               id_in_ready,
    output logic [NUM_ENG-1:0] eng_start,
    output logic [ID_W-1:0]    eng_id,
    input  logic [NUM_ENG-1:0] eng_done,
    output logic [ID_W-1:0]    id_out,
    output logic               id_out_last,
    output logic               id_out_valid,
    input  logic               id_out_ready,
    output logic [NUM_ENG-1:0] alloc_mask,
    output logic               err_spurious
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_ENG-1:0] r_alloc;
    logic [NUM_ENG-1:0] r_done;
    logic [c_IDX_W-1:0] r_rr;
    logic [NUM_ENG-1:0] r_eng_start;
    logic [ID_W-1:0]    r_eng_id;
    // Output stage: holds the entry being offered on id_out. The entry is
    // popped from the order FIFO when loaded here, but its engine stays
    // allocated until the id_out handshake.
    logic               r_out_valid;
    logic [ID_W-1:0]    r_out_id;
    logic               r_out_last;
    logic [NUM_ENG-1:0] r_out_oh;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [c_MAX_ENG-1:0] w_free_ext;
    logic [c_IDX_W-1:0]   w_sel;
    logic [NUM_ENG-1:0]   w_sel_oh;
    logic [NUM_ENG-1:0]   w_head_oh;
    logic                 w_disp;
    logic                 w_head_done;
    logic                 w_load;
    logic                 w_retire;
    logic [NUM_ENG-1:0]   w_retire_clr;
    logic [NUM_ENG-1:0]   w_done_ok;
    logic                 w_fifo_empty;
    logic                 w_fifo_full;
    sched_entry_t         w_push_entry;
    sched_entry_t         w_head;

    always_comb begin
        w_free_ext              = '0;
        w_free_ext[NUM_ENG-1:0] = ~r_alloc;
    end

    // Selection uses registered alloc, so an engine freed this cycle is
    // not a candidate until the next one.
    assign w_sel = rr_search(w_free_ext, r_rr, NUM_ENG);

    always_comb begin
        w_sel_oh  = '0;
        w_head_oh = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            w_sel_oh[i]  = (w_sel == c_IDX_W'(i));
            w_head_oh[i] = (w_head.idx == c_IDX_W'(i));
        end
    end

    // Only registered state and en/sync_rst feed ready.
    assign id_in_ready = ~sync_rst & en & ~(&r_alloc) & ~w_fifo_full;
    assign w_disp      = id_in_valid & id_in_ready;

    always_comb begin
        w_push_entry      = '0;
        w_push_entry.idx  = w_sel;
        w_push_entry.id   = id_in;
        w_push_entry.last = id_in_last;
    end

    // A done pulse only counts for an allocated engine that has not yet
    // reported; this also makes a pulse in the dispatch cycle spurious.
    assign w_done_ok    = eng_done & r_alloc & ~r_done;
    assign w_head_done  = ~w_fifo_empty & (|(r_done & w_head_oh));
    assign w_retire     = r_out_valid & id_out_ready;
    assign w_load       = w_head_done & (~r_out_valid | id_out_ready);
    assign w_retire_clr = w_retire ? r_out_oh : '0;

    sha256_sched_order_fifo #(
        .DEPTH (NUM_ENG),
        .WIDTH ($bits(sched_entry_t))
    ) u_order_fifo (
        .clk     (clk),
        .rst     (sync_rst),
        .i_push  (w_disp),
        .i_data  (w_push_entry),
        .i_pop   (w_load),
        .o_head  (w_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_alloc     <= '0;
            r_done      <= '0;
            r_rr        <= '0;
            r_eng_start <= '0;
            r_eng_id    <= '0;
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
            r_out_last  <= 1'b0;
            r_out_oh    <= '0;
        end else begin
            r_alloc     <= (r_alloc & ~w_retire_clr) | (w_disp ? w_sel_oh : '0);
            r_done      <= (r_done | w_done_ok) & ~w_retire_clr;
            r_eng_start <= w_disp ? w_sel_oh : '0;
            if (w_disp) begin
                r_rr     <= (w_sel == c_IDX_W'(NUM_ENG - 1)) ? '0 : w_sel + 1'b1;
                r_eng_id <= id_in;
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_id    <= w_head.id;
                r_out_last  <= w_head.last;
                r_out_oh    <= w_head_oh;
            end else if (w_retire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef SHA256_SCHED_ERR_EN
    logic r_err;
    logic w_spurious;

    assign w_spurious = |(eng_done & ~(r_alloc & ~r_done));

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_err <= 1'b0;
        end else if (w_spurious) begin
            r_err <= 1'b1;
        end
    end

    assign err_spurious = r_err;
`else
    assign err_spurious = 1'b0;
`endif

    assign eng_start    = r_eng_start;
    assign eng_id       = r_eng_id;
    assign id_out       = r_out_id;
    assign id_out_last  = r_out_last;
    assign id_out_valid = r_out_valid;
    assign alloc_mask   = r_alloc;

endmodule
`default_nettype wire

// File: tb/tb_sha256_engine_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_engine_sched
// Description : Self-checking bench for sha256_engine_sched (NUM_ENG=4).
//               Directed scenarios plus a randomized run compared against a
//               behavioural model built from the dispatch/retire rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_engine_sched;

    localparam int NUM_ENG = 4;
    localparam int ID_W    = 6;
`ifdef SHA256_SCHED_ERR_EN
    localparam bit c_ERR_EXP = 1'b1;
`else
    localparam bit c_ERR_EXP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               sync_rst = 1'b1;
    logic               en = 1'b1;
    logic [ID_W-1:0]    id_in = '0;
    logic               id_in_last = 1'b0;
    logic               id_in_valid = 1'b0;
    logic               id_in_ready;
    logic [NUM_ENG-1:0] eng_start;
    logic [ID_W-1:0]    eng_id;
    logic [NUM_ENG-1:0] eng_done = '0;
    logic [ID_W-1:0]    id_out;
    logic               id_out_last;
    logic               id_out_valid;
    logic               id_out_ready = 1'b1;
    logic [NUM_ENG-1:0] alloc_mask;
    logic               err_spurious;

    sha256_engine_sched #(
        .NUM_ENG (NUM_ENG),
        .ID_W    (ID_W)
    ) dut (
        .clk          (clk),
        .sync_rst     (sync_rst),
        .en           (en),
        .id_in        (id_in),
        .id_in_last   (id_in_last),
        .id_in_valid  (id_in_valid),
        .id_in_ready  (id_in_ready),
        .eng_start    (eng_start),
        .eng_id       (eng_id),
        .eng_done     (eng_done),
        .id_out       (id_out),
        .id_out_last  (id_out_last),
        .id_out_valid (id_out_valid),
        .id_out_ready (id_out_ready),
        .alloc_mask   (alloc_mask),
        .err_spurious (err_spurious)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ------------------------------------------------------------------
    // Reference model: dispatch-order queue, per-engine alloc/done flags
    // and the edge at which each done was captured. An ID is offered on
    // id_out from the edge after its done capture, once it heads the queue.
    // ------------------------------------------------------------------
    typedef struct {
        int              eng;
        logic [ID_W-1:0] id;
        bit              last;
    } ent_t;

    ent_t            m_q[$];
    bit [3:0]        m_alloc = '0;
    bit [3:0]        m_done = '0;
    bit [3:0]        m_start = '0;
    int              m_done_cyc[NUM_ENG];
    int              m_rr = 0;
    bit              m_err = 1'b0;
    bit              m_vld = 1'b0;
    logic [ID_W-1:0] m_eng_id = '0;
    int              cyc = 0;

    // Apply one clock edge to the model using the inputs now driven, then
    // advance the real clock and settle 1 time unit past the edge.
    task automatic tick();
        int       sel;
        bit       disp;
        bit       ret;
        ent_t     e;
        bit [3:0] n_alloc;
        bit [3:0] n_done;
        sel = -1;
        if (sync_rst) begin
            m_alloc  = '0;
            m_done   = '0;
            m_q.delete();
            m_rr     = 0;
            m_err    = 1'b0;
            m_start  = '0;
            m_eng_id = '0;
        end else begin
            n_alloc = m_alloc;
            n_done  = m_done;
            disp    = id_in_valid && en && (m_alloc != 4'hF);
            ret     = m_vld && id_out_ready;
            for (int i = 0; i < NUM_ENG; i++) begin
                if (eng_done[i]) begin
                    if (m_alloc[i] && !m_done[i]) begin
                        n_done[i]     = 1'b1;
                        m_done_cyc[i] = cyc + 1;
                    end else if (c_ERR_EXP) begin
                        m_err = 1'b1;
                    end
                end
            end
            if (ret) begin
                e = m_q.pop_front();
                n_alloc[e.eng] = 1'b0;
                n_done[e.eng]  = 1'b0;
            end
            m_start = '0;
            if (disp) begin
                for (int k = 0; k < NUM_ENG; k++) begin
                    if (sel < 0 && !m_alloc[(m_rr + k) % NUM_ENG]) sel = (m_rr + k) % NUM_ENG;
                end
                n_alloc[sel] = 1'b1;
                e.eng  = sel;
                e.id   = id_in;
                e.last = id_in_last;
                m_q.push_back(e);
                m_rr         = (sel + 1) % NUM_ENG;
                m_start[sel] = 1'b1;
                m_eng_id     = id_in;
            end
            m_alloc = n_alloc;
            m_done  = n_done;
        end
        @(posedge clk);
        cyc++;
        #1;
        m_vld = (m_q.size() > 0) && m_done[m_q[0].eng] && (m_done_cyc[m_q[0].eng] <= cyc - 1);
    endtask

    task automatic do_reset();
        sync_rst    = 1'b1;
        id_in_valid = 1'b0;
        eng_done    = '0;
        tick();
        sync_rst    = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        sync_rst = 1'b1; en = 1'b1; id_in_valid = 1'b0; eng_done = '0; id_out_ready = 1'b1;
        #1;
        n_checks++;
        if (id_in_ready !== 1'b0) begin n_errors++; $display("FAIL rst_ready_during: got %b expected 0", id_in_ready); end
        tick();
        n_checks++;
        if ({eng_start, eng_id, id_out, id_out_last, id_out_valid, alloc_mask, err_spurious} !== '0) begin
            n_errors++;
            $display("FAIL rst_outputs: got start=%b id=%h out=%h last=%b vld=%b alloc=%b err=%b expected all 0",
                     eng_start, eng_id, id_out, id_out_last, id_out_valid, alloc_mask, err_spurious);
        end
        sync_rst = 1'b0;
        #1;
        n_checks++;
        if (id_in_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready_after: got %b expected 1", id_in_ready); end
        en = 1'b0;
        #1;
        n_checks++;
        if (id_in_ready !== 1'b0) begin n_errors++; $display("FAIL ready_en_low: got %b expected 0", id_in_ready); end
        en = 1'b1;
    endtask

    task automatic test_basic_order();
        int got_n;
        id_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            id_in = 6'(k); id_in_last = (k == 3); id_in_valid = 1'b1;
            tick();
            n_checks++;
            if (eng_start !== 4'(1 << k) || eng_id !== 6'(k)) begin
                n_errors++; $display("FAIL basic_start%0d: got %b/%h expected %b/%h", k, eng_start, eng_id, 4'(1 << k), 6'(k));
            end
        end
        id_in_valid = 1'b0; id_in_last = 1'b0;
        n_checks++;
        if (alloc_mask !== 4'hF) begin n_errors++; $display("FAIL basic_alloc_full: got %b expected 1111", alloc_mask); end
        got_n = 0;
        for (int c = 0; c < 12; c++) begin
            eng_done = (c < 4) ? 4'(1 << c) : 4'h0;
            tick();
            if (id_out_valid) begin
                n_checks++;
                if (id_out !== 6'(got_n) || id_out_last !== (got_n == 3)) begin
                    n_errors++; $display("FAIL basic_out%0d: got %h/%b expected %h/%b", got_n, id_out, id_out_last, 6'(got_n), got_n == 3);
                end
                got_n++;
            end
        end
        eng_done = '0;
        n_checks++;
        if (got_n != 4 || alloc_mask !== 4'h0) begin
            n_errors++; $display("FAIL basic_count: got %0d outputs alloc=%b expected 4 alloc=0000", got_n, alloc_mask);
        end
    endtask

    task automatic test_out_of_order();
        logic [5:0] ids [3];
        ids[0] = 6'd5; ids[1] = 6'd6; ids[2] = 6'd7;
        for (int k = 0; k < 3; k++) begin
            id_in = ids[k]; id_in_last = (k == 2); id_in_valid = 1'b1;
            tick();
            n_checks++;
            if (eng_start !== 4'(1 << k)) begin n_errors++; $display("FAIL ooo_start%0d: got %b expected %b", k, eng_start, 4'(1 << k)); end
        end
        id_in_valid = 1'b0; id_in_last = 1'b0;
        eng_done = 4'b0100; tick();
        eng_done = 4'b0010; tick();
        eng_done = 4'b0000; tick();
        n_checks++;
        if (id_out_valid !== 1'b0) begin n_errors++; $display("FAIL ooo_early_valid: got %b expected 0", id_out_valid); end
        eng_done = 4'b0001; tick();
        eng_done = 4'b0000;
        n_checks++;
        if (id_out_valid !== 1'b0) begin n_errors++; $display("FAIL ooo_latency: got %b expected 0", id_out_valid); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (id_out_valid !== 1'b1 || id_out !== ids[k] || id_out_last !== (k == 2)) begin
                n_errors++; $display("FAIL ooo_out%0d: got v=%b %h/%b expected v=1 %h/%b", k, id_out_valid, id_out, id_out_last, ids[k], k == 2);
            end
        end
        tick();
        n_checks++;
        if (id_out_valid !== 1'b0 || alloc_mask !== 4'h0) begin
            n_errors++; $display("FAIL ooo_drain: got v=%b alloc=%b expected v=0 alloc=0000", id_out_valid, alloc_mask);
        end
    endtask

    task automatic test_full_pool();
        do_reset();
        id_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            id_in = 6'(10 + k); id_in_valid = 1'b1;
            tick();
            n_checks++;
            if (eng_start !== 4'(1 << k)) begin n_errors++; $display("FAIL full_start%0d: got %b expected %b", k, eng_start, 4'(1 << k)); end
        end
        id_in = 6'd14;
        n_checks++;
        if (id_in_ready !== 1'b0 || alloc_mask !== 4'hF) begin
            n_errors++; $display("FAIL full_ready: got rdy=%b alloc=%b expected rdy=0 alloc=1111", id_in_ready, alloc_mask);
        end
        eng_done = 4'b0001; tick();
        eng_done = 4'b0000;
        tick();
        n_checks++;
        if (id_out_valid !== 1'b1 || id_out !== 6'd10 || id_in_ready !== 1'b0) begin
            n_errors++; $display("FAIL full_out: got v=%b id=%h rdy=%b expected v=1 id=0a rdy=0", id_out_valid, id_out, id_in_ready);
        end
        tick();
        n_checks++;
        if (alloc_mask !== 4'b1110 || id_in_ready !== 1'b1 || eng_start !== 4'h0) begin
            n_errors++; $display("FAIL full_free: got alloc=%b rdy=%b start=%b expected 1110/1/0000", alloc_mask, id_in_ready, eng_start);
        end
        tick();
        id_in_valid = 1'b0;
        n_checks++;
        if (eng_start !== 4'b0001 || eng_id !== 6'd14 || alloc_mask !== 4'hF) begin
            n_errors++; $display("FAIL full_redispatch: got start=%b id=%h alloc=%b expected 0001/0e/1111", eng_start, eng_id, alloc_mask);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        id_out_ready = 1'b0;
        id_in = 6'd20; id_in_valid = 1'b1; tick();
        id_in = 6'd21; eng_done = 4'b0001; tick();
        id_in = 6'd22; eng_done = 4'b0000; tick();
        id_in = 6'd23;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 0) id_in = 6'd24;
            n_checks++;
            if (id_out_valid !== 1'b1 || id_out !== 6'd20) begin
                n_errors++; $display("FAIL bp_hold%0d: got v=%b id=%h expected v=1 id=14", c, id_out_valid, id_out);
            end
        end
        n_checks++;
        if (alloc_mask !== 4'hF || id_in_ready !== 1'b0) begin
            n_errors++; $display("FAIL bp_fill: got alloc=%b rdy=%b expected 1111/0", alloc_mask, id_in_ready);
        end
        id_out_ready = 1'b1;
        tick();
        n_checks++;
        if (id_out_valid !== 1'b0 || alloc_mask !== 4'b1110) begin
            n_errors++; $display("FAIL bp_release: got v=%b alloc=%b expected 0/1110", id_out_valid, alloc_mask);
        end
        tick();
        id_in_valid = 1'b0;
        n_checks++;
        if (eng_start !== 4'b0001 || eng_id !== 6'd24) begin
            n_errors++; $display("FAIL bp_redispatch: got %b/%h expected 0001/18", eng_start, eng_id);
        end
    endtask

    task automatic test_spurious();
        do_reset();
        id_out_ready = 1'b1;
        id_in = 6'd30; id_in_valid = 1'b1; tick();
        id_in = 6'd31; tick();
        id_in_valid = 1'b0;
        n_checks++;
        if (alloc_mask !== 4'b0011 || err_spurious !== 1'b0) begin
            n_errors++; $display("FAIL sp_pre: got alloc=%b err=%b expected 0011/0", alloc_mask, err_spurious);
        end
        eng_done = 4'hF; tick();
        eng_done = 4'h0;
        n_checks++;
        if (err_spurious !== c_ERR_EXP) begin n_errors++; $display("FAIL sp_err: got %b expected %b", err_spurious, c_ERR_EXP); end
        tick();
        n_checks++;
        if (id_out_valid !== 1'b1 || id_out !== 6'd30) begin
            n_errors++; $display("FAIL sp_out0: got v=%b id=%h expected 1/1e", id_out_valid, id_out);
        end
        tick();
        n_checks++;
        if (id_out_valid !== 1'b1 || id_out !== 6'd31) begin
            n_errors++; $display("FAIL sp_out1: got v=%b id=%h expected 1/1f", id_out_valid, id_out);
        end
        tick();
        n_checks++;
        if (id_out_valid !== 1'b0 || alloc_mask !== 4'h0 || err_spurious !== c_ERR_EXP) begin
            n_errors++; $display("FAIL sp_end: got v=%b alloc=%b err=%b expected 0/0000/%b", id_out_valid, alloc_mask, err_spurious, c_ERR_EXP);
        end
    endtask

    task automatic test_reset_midstream();
        id_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            id_in = 6'(40 + k); id_in_valid = 1'b1; tick();
        end
        id_in_valid = 1'b0;
        n_checks++;
        if (alloc_mask !== 4'b1101) begin n_errors++; $display("FAIL mr_pre: got alloc=%b expected 1101", alloc_mask); end
        sync_rst = 1'b1; tick(); sync_rst = 1'b0;
        n_checks++;
        if (alloc_mask !== 4'h0 || id_out_valid !== 1'b0 || err_spurious !== 1'b0 || eng_start !== 4'h0) begin
            n_errors++; $display("FAIL mr_clear: got alloc=%b v=%b err=%b start=%b expected all 0", alloc_mask, id_out_valid, err_spurious, eng_start);
        end
        eng_done = 4'b0100; tick(); eng_done = 4'b0000;
        n_checks++;
        if (err_spurious !== c_ERR_EXP || alloc_mask !== 4'h0) begin
            n_errors++; $display("FAIL mr_late_done: got err=%b alloc=%b expected %b/0000", err_spurious, alloc_mask, c_ERR_EXP);
        end
        id_in = 6'd43; id_in_valid = 1'b1; tick(); id_in_valid = 1'b0;
        n_checks++;
        if (eng_start !== 4'b0001 || eng_id !== 6'd43) begin
            n_errors++; $display("FAIL mr_dispatch: got %b/%h expected 0001/2b", eng_start, eng_id);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            sync_rst     = ($urandom_range(0, 63) == 0);
            en           = ($urandom_range(0, 7) != 0);
            id_in_valid  = $urandom_range(0, 1);
            id_in        = 6'($urandom);
            id_in_last   = $urandom_range(0, 1);
            id_out_ready = ($urandom_range(0, 2) != 0);
            r            = 4'($urandom);
            eng_done     = m_alloc & ~m_done & r;
            if ($urandom_range(0, 15) == 0) eng_done = eng_done | 4'($urandom);
            #1;
            n_checks++;
            if (id_in_ready !== (!sync_rst && en && m_alloc != 4'hF)) begin
                n_errors++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, id_in_ready, !sync_rst && en && m_alloc != 4'hF);
            end
            tick();
            n_checks++;
            if (alloc_mask !== m_alloc || id_out_valid !== m_vld || eng_start !== m_start || err_spurious !== m_err) begin
                n_errors++; $display("FAIL rnd_state c%0d: got alloc=%b v=%b start=%b err=%b expected %b/%b/%b/%b",
                                     c, alloc_mask, id_out_valid, eng_start, err_spurious, m_alloc, m_vld, m_start, m_err);
            end
            if (m_vld) begin
                n_checks++;
                if (id_out !== m_q[0].id || id_out_last !== m_q[0].last) begin
                    n_errors++; $display("FAIL rnd_out c%0d: got %h/%b expected %h/%b", c, id_out, id_out_last, m_q[0].id, m_q[0].last);
                end
            end
            if (m_start != 4'h0) begin
                n_checks++;
                if (eng_id !== m_eng_id) begin n_errors++; $display("FAIL rnd_engid c%0d: got %h expected %h", c, eng_id, m_eng_id); end
            end
        end
        sync_rst = 1'b0; eng_done = '0; id_in_valid = 1'b0; en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_out_of_order();
        test_full_pool();
        test_backpressure();
        test_spurious();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
